// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time programmable pattern/length (1..MAX_LEN),
// overlap control, Mealy and registered match outputs, and a saturating match counter.
module seq_detector_param #(
   parameter int unsigned        MAX_LEN     = 8,
   parameter int unsigned        LEN_W       = 4,
   parameter int unsigned        CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0101),
   parameter int unsigned        DEF_LEN     = 3,
   parameter bit                 DEF_OVERLAP = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               x,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               z,
   output logic               z_q,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err,
   output logic [LEN_W-1:0]   fill
);

   localparam logic [LEN_W:0]   MAX_LEN_X = (LEN_W+1)'(MAX_LEN);
   localparam logic [LEN_W:0]   ONE_X     = (LEN_W+1)'(1);
   localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] pattern_r;
   logic [LEN_W-1:0]   len_r;
   logic               overlap_r;
   // The oldest history bit is never compared, so only MAX_LEN-1 bits are stored.
   logic [MAX_LEN-2:0] hist;

   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] mask;
   logic               cfg_ok;
   logic               match;

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < 32'(len_r));
      end
      window = {hist, x};
      cfg_ok = (cfg_len != '0) && ({1'b0, cfg_len} <= MAX_LEN_X);
      match  = rst && en && !cfg_we
               && (({1'b0, fill} + ONE_X) >= {1'b0, len_r})
               && ((window & mask) == (pattern_r & mask));
   end

   assign z = match;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern_r <= DEF_PATTERN;
         len_r     <= LEN_W'(DEF_LEN);
         overlap_r <= DEF_OVERLAP;
         hist      <= '0;
         fill      <= '0;
         z_q       <= 1'b0;
         match_cnt <= '0;
         cfg_err   <= 1'b0;
      end else begin
         z_q     <= match;
         cfg_err <= cfg_we && !cfg_ok;

         if (cnt_clr) begin
            match_cnt <= '0;
         end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
         end

         if (cfg_we) begin
            fill <= '0;
            if (cfg_ok) begin
               pattern_r <= cfg_pattern;
               len_r     <= cfg_len;
               overlap_r <= cfg_overlap;
            end
         end else if (en) begin
            hist <= window[MAX_LEN-2:0];
            if (match && !overlap_r) begin
               fill <= '0;
            end else if (fill != FILL_MAX) begin
               fill <= fill + LEN_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: per-cycle z checks, z_q via expected-value queue,
// plus counter, fill and cfg_err checks at the points of interest.
module tb_seq_detector_param;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned LEN_W   = 4;
   localparam int unsigned CNT_W   = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               en = 1'b0;
   logic               x = 1'b0;
   logic               cfg_we = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               cnt_clr = 1'b0;
   logic               z;
   logic               z_q;
   logic [CNT_W-1:0]   match_cnt;
   logic               cfg_err;
   logic [LEN_W-1:0]   fill;

   int checks = 0;
   int errors = 0;
   logic exp_q[$];

   seq_detector_param #(
      .MAX_LEN(MAX_LEN),
      .LEN_W  (LEN_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .x          (x),
      .cfg_we     (cfg_we),
      .cfg_pattern(cfg_pattern),
      .cfg_len    (cfg_len),
      .cfg_overlap(cfg_overlap),
      .cnt_clr    (cnt_clr),
      .z          (z),
      .z_q        (z_q),
      .match_cnt  (match_cnt),
      .cfg_err    (cfg_err),
      .fill       (fill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check Mealy z, queue it, then check z_q after the edge.
   task automatic cyc(input logic e, input logic xi, input logic we, input logic clr,
                      input logic exp_z);
      logic ez;
      @(negedge clk);
      en = e; x = xi; cfg_we = we; cnt_clr = clr;
      #1;
      chk("z", 32'(z), 32'(exp_z));
      exp_q.push_back(exp_z);
      @(posedge clk);
      #1;
      ez = exp_q.pop_front();
      chk("z_q", 32'(z_q), 32'(ez));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
      #1;
      chk("rst_z", 32'(z), 32'd0);
      chk("rst_zq", 32'(z_q), 32'd0);
      chk("rst_cnt", 32'(match_cnt), 32'd0);
      chk("rst_fill", 32'(fill), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
   endtask

   task automatic set_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                          input logic ov, input logic exp_err);
      cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("cfg_err", 32'(cfg_err), 32'(exp_err));
      chk("cfg_fill", 32'(fill), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cfg_err_pulse", 32'(cfg_err), 32'd0);
   endtask

   initial begin
      do_reset();

      // 1: defaults, overlapping 101
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 1);
      chk("t1_cnt", 32'(match_cnt), 32'd2);
      chk("t1_fill", 32'(fill), 32'd5);

      // 2: non-overlapping 101
      set_cfg(8'b0000_0101, 4'd3, 1'b0, 1'b0);
      cyc(0, 0, 0, 1, 0);
      chk("t2_clr", 32'(match_cnt), 32'd0);
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 1); cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 1);
      chk("t2_cnt", 32'(match_cnt), 32'd2);

      // 3: full-length pattern 11010011
      set_cfg(8'b1101_0011, 4'd8, 1'b1, 1'b0);
      cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 1);
      chk("t3_cnt", 32'(match_cnt), 32'd3);
      set_cfg(8'b1101_0011, 4'd8, 1'b1, 1'b0);
      cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
      chk("t3_err_cnt", 32'(match_cnt), 32'd3);

      // 4: en=0 holds state across a gap
      set_cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0);
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
      chk("t4_hold_cnt", 32'(match_cnt), 32'd3);
      chk("t4_hold_fill", 32'(fill), 32'd2);
      cyc(1, 1, 0, 0, 1);
      chk("t4_cnt", 32'(match_cnt), 32'd4);

      // 5: illegal lengths rejected, configuration retained
      set_cfg(8'hFF, 4'd0, 1'b0, 1'b1);
      set_cfg(8'hFF, 4'd9, 1'b0, 1'b1);
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 1);
      chk("t5_cnt", 32'(match_cnt), 32'd6);

      // 6: len=1, saturation, clear priority, reset mid-pattern
      set_cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 1);
      chk("t6_sat", 32'(match_cnt), 32'd7);
      chk("t6_fill_sat", 32'(fill), 32'd8);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 1);
      chk("t6_clr_wins", 32'(match_cnt), 32'd0);
      do_reset();
      cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      do_reset();
      cyc(1, 1, 0, 0, 0);
      chk("t6_post_rst_cnt", 32'(match_cnt), 32'd0);
      chk("t6_post_rst_fill", 32'(fill), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised successor to the team's fixed 3-bit Mealy "101" detector. Detects a run-time programmable serial bit pattern of 1..MAX_LEN bits on input x. Supports overlapping and non-overlapping match modes, and provides both Mealy and registered outputs plus a saturating match counter. Sits on serial bit streams (one bit per enabled clk) in the same control datapath as the existing detector and is a drop-in replacement when configured for "101" with overlap.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of length fields; must hold MAX_LEN
CNT_W, 8, width of match counter
DEF_PATTERN, 8'b0000_0101, pattern loaded at reset (LSB-aligned)
DEF_LEN, 3, length loaded at reset
DEF_OVERLAP, 1, overlap mode loaded at reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  x is sampled only when en=1
x  input  1  serial data bit
cfg_we  input  1  one-cycle pulse; latch cfg_* fields
cfg_pattern  input  MAX_LEN  pattern; bit[len-1] is the first bit received, bit[0] the last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1=overlapping matches allowed, 0=non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt
z  output  1  Mealy match: combinational, same cycle as the completing bit
z_q  output  1  registered match: z delayed one clk
match_cnt  output  CNT_W  saturating count of matches
cfg_err  output  1  one-cycle pulse: illegal cfg_len rejected
fill  output  LEN_W  valid history bits since reset, reconfig or non-overlap match (saturates at MAX_LEN)

Behaviour:
- Reset (rst=0, async): pattern/len/overlap <- DEF_*; history <- 0; fill <- 0; z_q <- 0; match_cnt <- 0; cfg_err <- 0. z=0 while in reset.
- History: MAX_LEN-bit shift register. On en=1 and cfg_we=0: hist <- {hist[MAX_LEN-2:0], x}; fill <- min(fill+1, MAX_LEN).
- Match condition (combinational): en=1, cfg_we=0, fill+1 >= len, and low len bits of {hist, x} equal pattern[len-1:0]. z = match.
- Overlap=1: after a match, fill and hist continue unchanged, so the suffix can start the next match ("10101" with 101 gives 2 matches).
- Overlap=0: on a match, fill <- 0 at the clock edge (history content is don't-care), so the next match needs len fresh bits ("10101" with 101 gives 1 match).
- en=0: hist, fill, and match_cnt hold; z=0; z_q <- 0 at the next edge.
- z_q <- z every clk. Latency is 1 cycle after z.
- match_cnt: increments on each clk where z=1; saturates at 2^CNT_W-1 (no wrap). cnt_clr=1 forces 0 and wins over a simultaneous match.
- cfg_we=1 with legal cfg_len (1..MAX_LEN):
  - latch pattern, len, overlap;
  - fill <- 0 (history flushed);
  - x that cycle is ignored and z=0;
  - match_cnt is not affected.
- cfg_we with cfg_len=0 or cfg_len>MAX_LEN: configuration unchanged; cfg_err=1 for exactly one cycle; fill is still flushed; z=0.
- Reset mid-stream: all state returns to the DEF_* configuration immediately; no partial match survives.
- len=1: every en cycle with x=pattern[0] matches. In non-overlap mode this is identical to overlap mode.

Test Plan:
1. Defaults (101, len 3, overlap), en=1, x=1,0,1,0,1 -> z=1 on bits 3 and 5; z_q=1 one cycle after each; match_cnt=2.
2. cfg_we with cfg_pattern=8'b0000_0101, cfg_len=3, cfg_overlap=0; x=1,0,1,0,1,0,1 -> z=1 on bits 3 and 7 only; match_cnt=2.
3. cfg_pattern=8'b1101_0011, cfg_len=8; stream 0,1,1,0,1,0,0,1,1 -> single z pulse on the 9th bit; a deliberate bit error gives no match.
4. Defaults; x=1,0 then en=0 for 3 cycles, then en=1 with x=1 -> z=1 on resume; z=0 and match_cnt held during en=0.
5. cfg_len=0, then cfg_len=9 -> cfg_err pulses twice; default 101 still detected afterwards; fill=0 after each cfg_we.
6. CNT_W=3, overlap, len=1, pattern=1; 10 ones -> match_cnt saturates at 7; cnt_clr coincident with a match -> 0; rst asserted mid-pattern "10" -> the next "1" gives no match.
